// File: rtl/dmem_pkg.sv
// Shared encodings and pipeline records for the byte-addressable data memory.
// Also holds the access-fault classifier used on the request path.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] EXC_NONE        = 4'd0;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  // Stage holding an accepted request while its word is read from the array.
  typedef struct packed {
    logic       valid;
    logic       we;
    logic [2:0] funct3;
    logic [1:0] offset;
    logic       exc;
    logic [3:0] exc_code;
  } req_stage_t;

  // Fully formatted response, carried through the extra latency stages.
  typedef struct packed {
    logic        valid;
    logic        exc;
    logic [3:0]  exc_code;
    logic [31:0] rdata;
  } resp_stage_t;

  // Misalignment wins over illegal funct3 / out-of-range address.
  function automatic logic [3:0] access_fault_code(
    input logic       we,
    input logic [2:0] funct3,
    input logic [1:0] offset,
    input logic       oor
  );
    logic misalign;
    logic illegal;
    if (we) begin
      illegal  = funct3[2] || (funct3[1] && funct3[0]);
      misalign = ((funct3 == F3_H) && offset[0]) ||
                 ((funct3 == F3_W) && (offset != 2'b00));
    end else begin
      illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && offset[0]) ||
                 ((funct3 == F3_W) && (offset != 2'b00));
    end
    if (misalign) begin
      return we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    end else if (illegal || oor) begin
      return we ? EXC_ST_FAULT : EXC_LD_FAULT;
    end
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store byte-enables / lane-replicated write data,
// and load lane extraction with sign or zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (st_funct3_i)
      F3_B:    st_be_o = 4'b0001 << st_offset_i;
      F3_H:    st_be_o = st_offset_i[1] ? 4'b1100 : 4'b0011;
      F3_W:    st_be_o = 4'b1111;
      default: st_be_o = 4'b0000;
    endcase
  end

  // Data is replicated across lanes so the byte-enables alone pick the target.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_wdata_o[gi*8 +: 8] =
      (st_funct3_i == F3_B) ? st_wdata_i[7:0] :
      (st_funct3_i == F3_H) ? st_wdata_i[(gi%2)*8 +: 8] :
                              st_wdata_i[gi*8 +: 8];
  end

  always_comb begin
    case (ld_offset_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = ld_offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data_o = ld_word_i;
      F3_BU:   ld_data_o = {24'd0, ld_byte};
      F3_HU:   ld_data_o = {16'd0, ld_half};
      default: ld_data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined RV32I data memory: stores commit on the accept edge, every request
// gets one in-order response LATENCY cycles later; a full stall freezes all stages.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_exception,
  output logic [3:0]  resp_exc_code
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_word_q;
  logic [AW-1:0] word_idx;
  logic          addr_oor;
  logic [3:0]    req_code;
  logic          req_exc;
  logic          advance;
  logic          accept;
  logic          wr_en;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   ld_data;
  req_stage_t    s0_q;
  req_stage_t    s0_d;
  resp_stage_t   r0;
  resp_stage_t   resp_out;

  assign word_idx = req_addr[AW+1:2];
  assign addr_oor = |req_addr[31:AW+2];
  assign req_code = access_fault_code(req_we, req_funct3, req_addr[1:0], addr_oor);
  assign req_exc  = (req_code != EXC_NONE);
  assign advance  = req_ready;
  assign accept   = req_valid && advance;
  assign wr_en    = accept && req_we && !req_exc;

  dmem_lane_fmt u_lane_fmt (
    .st_funct3_i (req_funct3),
    .st_offset_i (req_addr[1:0]),
    .st_wdata_i  (req_wdata),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (s0_q.funct3),
    .ld_offset_i (s0_q.offset),
    .ld_word_i   (rd_word_q),
    .ld_data_o   (ld_data)
  );

  // Array with byte-enable write and enabled registered read (block-RAM shape).
  always_ff @(posedge clk) begin
    if (advance) begin
      rd_word_q <= mem[word_idx];
    end
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem[word_idx][b*8 +: 8] <= st_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    s0_d = s0_q;
    if (advance) begin
      s0_d.valid    = req_valid;
      s0_d.we       = req_we;
      s0_d.funct3   = req_funct3;
      s0_d.offset   = req_addr[1:0];
      s0_d.exc      = req_exc;
      s0_d.exc_code = req_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
    end else begin
      s0_q <= s0_d;
    end
  end

  // Formatting sits after the array register; every input here is a flop.
  always_comb begin
    r0.valid    = s0_q.valid;
    r0.exc      = s0_q.exc;
    r0.exc_code = s0_q.exc_code;
    r0.rdata    = (s0_q.we || s0_q.exc) ? 32'd0 : ld_data;
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign resp_out = r0;
    end else begin : g_latn
      resp_stage_t resp_q [LATENCY-1];
      resp_stage_t resp_d [LATENCY-1];
      for (genvar gi = 0; gi < LATENCY-1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          assign resp_d[gi] = advance ? r0 : resp_q[gi];
        end else begin : g_rest
          assign resp_d[gi] = advance ? resp_q[gi-1] : resp_q[gi];
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            resp_q[gi] <= '0;
          end else begin
            resp_q[gi] <= resp_d[gi];
          end
        end
      end
      assign resp_out = resp_q[LATENCY-2];
    end
  endgenerate

  assign resp_valid     = resp_out.valid;
  assign resp_rdata     = resp_out.valid ? resp_out.rdata : 32'd0;
  assign resp_exception = resp_out.valid && resp_out.exc;
  assign resp_exc_code  = resp_out.valid ? resp_out.exc_code : EXC_NONE;
  assign req_ready      = !(resp_valid && !resp_ready);

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench: LATENCY=1 and LATENCY=3 instances share request stimulus;
// single transactions check both, streams with stalls check the deep one.
module tb_dmem_pipe;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready1, resp_ready3;
  logic        req_ready1, req_ready3;
  logic        resp_valid1, resp_valid3;
  logic [31:0] resp_rdata1, resp_rdata3;
  logic        resp_exception1, resp_exception3;
  logic [3:0]  resp_exc_code1, resp_exc_code3;

  int n_checks = 0;
  int n_pass   = 0;

  logic        s_we    [16];
  logic [2:0]  s_f3    [16];
  logic [31:0] s_addr  [16];
  logic [31:0] s_wdata [16];
  logic [31:0] s_exp   [16];
  logic [3:0]  s_code  [16];
  int          s_n = 0;

  always #5 clk = ~clk;

  dmem_pipe #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
    .resp_exception(resp_exception1), .resp_exc_code(resp_exc_code1)
  );

  dmem_pipe #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready3), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3),
    .resp_exception(resp_exception3), .resp_exc_code(resp_exc_code3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic single(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_code);
    logic exp_exc;
    exp_exc = (exp_code != 4'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1 check_eq({tag, ".ready"}, {31'd0, req_ready3}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_eq({tag, ".l1.valid"}, {31'd0, resp_valid1}, 32'd1);
        check_eq({tag, ".l1.rdata"}, resp_rdata1, exp_rdata);
        check_eq({tag, ".l1.exc"}, {31'd0, resp_exception1}, {31'd0, exp_exc});
        check_eq({tag, ".l1.code"}, {28'd0, resp_exc_code1}, {28'd0, exp_code});
      end
      if (k == 2) check_eq({tag, ".l1.once"}, {31'd0, resp_valid1}, 32'd0);
      check_eq($sformatf("%s.l3.valid@%0d", tag, k), {31'd0, resp_valid3}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        check_eq({tag, ".l3.rdata"}, resp_rdata3, exp_rdata);
        check_eq({tag, ".l3.exc"}, {31'd0, resp_exception3}, {31'd0, exp_exc});
        check_eq({tag, ".l3.code"}, {28'd0, resp_exc_code3}, {28'd0, exp_code});
      end
    end
    $display("txn %-8s we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h exc=%0d code=%0d",
             tag, we, f3, addr, wdata, resp_rdata3, resp_exception3, resp_exc_code3);
  endtask

  task automatic add_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, input logic [3:0] code);
    s_we[s_n] = we; s_f3[s_n] = f3; s_addr[s_n] = addr;
    s_wdata[s_n] = wdata; s_exp[s_n] = exp; s_code[s_n] = code;
    s_n++;
  endtask

  // Back-to-back issue into the LATENCY=3 instance; resp_ready low for cycles lo..hi.
  task automatic run_stream(input string tag, input int lo, input int hi);
    int sidx = 0;
    int ridx = 0;
    int c = 0;
    int extra = 0;
    bit acc;
    bit stall;
    while (ridx < s_n && c < 60) begin
      @(negedge clk);
      c++;
      stall = (c >= lo && c <= hi);
      resp_ready3 = !stall;
      if (sidx < s_n) begin
        req_valid = 1'b1; req_we = s_we[sidx]; req_funct3 = s_f3[sidx];
        req_addr = s_addr[sidx]; req_wdata = s_wdata[sidx];
      end else begin
        req_valid = 1'b0;
      end
      #1;
      check_eq($sformatf("%s.ready@%0d", tag, c), {31'd0, req_ready3}, stall ? 32'd0 : 32'd1);
      if (resp_valid3 && resp_ready3) begin
        check_eq($sformatf("%s.rdata[%0d]", tag, ridx), resp_rdata3, s_exp[ridx]);
        check_eq($sformatf("%s.code[%0d]", tag, ridx), {28'd0, resp_exc_code3}, {28'd0, s_code[ridx]});
        $display("txn %s[%0d] cycle=%0d addr=0x%08h -> rdata=0x%08h code=%0d",
                 tag, ridx, c, s_addr[ridx], resp_rdata3, resp_exc_code3);
        ridx++;
      end
      acc = req_valid && req_ready3;
      @(posedge clk);
      if (acc) sidx++;
    end
    req_valid = 1'b0;
    resp_ready3 = 1'b1;
    check_eq({tag, ".count"}, ridx, s_n);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid3) extra++;
    end
    check_eq({tag, ".extra"}, extra, 32'd0);
    s_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready1 = 1'b1; resp_ready3 = 1'b1;

    @(negedge clk);
    check_eq("rst.valid", {31'd0, resp_valid3}, 32'd0);
    check_eq("rst.ready", {31'd0, req_ready3}, 32'd1);
    check_eq("rst.rdata", resp_rdata3, 32'd0);
    check_eq("rst.exc", {31'd0, resp_exception3}, 32'd0);
    check_eq("rst.code", {28'd0, resp_exc_code3}, 32'd0);
    check_eq("rst.l1valid", {31'd0, resp_valid1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    single("sw10",   1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 4'd0);
    single("lb13",   1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 4'd0);
    single("lbu13",  1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 4'd0);
    single("lh12",   1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 4'd0);
    single("lhu10",  1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 4'd0);
    single("lb10",   1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFEF, 4'd0);
    single("lw10",   1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 4'd0);
    single("sw00",   1'b1, F3_W,  32'h0,  32'h55AA55AA, 32'h0, 4'd0);
    single("sw1000", 1'b1, F3_W,  32'h1000, 32'h12345678, 32'h0, 4'd7);
    single("lw1000", 1'b0, F3_W,  32'h1000, 32'h0, 32'h0, 4'd5);
    single("lw00",   1'b0, F3_W,  32'h0,  32'h0, 32'h55AA55AA, 4'd0);
    single("ld011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 4'd5);
    single("st011",  1'b1, 3'b011, 32'h0, 32'hFFFFFFFF, 32'h0, 4'd7);
    single("lw00b",  1'b0, F3_W,  32'h0,  32'h0, 32'h55AA55AA, 4'd0);
    single("lw22",   1'b0, F3_W,  32'h22, 32'h0, 32'h0, 4'd4);
    single("sw30",   1'b1, F3_W,  32'h30, 32'h01234567, 32'h0, 4'd0);
    single("sh31",   1'b1, F3_H,  32'h31, 32'h0000FFFF, 32'h0, 4'd6);
    single("lw30",   1'b0, F3_W,  32'h30, 32'h0, 32'h01234567, 4'd0);
    single("lhu11",  1'b0, F3_HU, 32'h11, 32'h0, 32'h0, 4'd4);
    single("sb31",   1'b1, F3_B,  32'h31, 32'h000000AA, 32'h0, 4'd0);
    single("lw30b",  1'b0, F3_W,  32'h30, 32'h0, 32'h0123AA67, 4'd0);
    single("lb31",   1'b0, F3_B,  32'h31, 32'h0, 32'hFFFFFFAA, 4'd0);

    add_req(1'b1, F3_W,  32'h20, 32'h00000000, 32'h0, 4'd0);
    add_req(1'b1, F3_B,  32'h21, 32'h0000007F, 32'h0, 4'd0);
    add_req(1'b0, F3_W,  32'h20, 32'h0, 32'h00007F00, 4'd0);
    add_req(1'b1, F3_H,  32'h22, 32'h0000BEEF, 32'h0, 4'd0);
    add_req(1'b0, F3_W,  32'h20, 32'h0, 32'hBEEF7F00, 4'd0);
    add_req(1'b0, F3_BU, 32'h23, 32'h0, 32'h000000BE, 4'd0);
    add_req(1'b0, F3_H,  32'h22, 32'h0, 32'hFFFFBEEF, 4'd0);
    run_stream("b2b", 100, 0);

    add_req(1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 4'd0);
    add_req(1'b0, F3_W,  32'h20, 32'h0, 32'hBEEF7F00, 4'd0);
    add_req(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 4'd0);
    add_req(1'b0, F3_BU, 32'h21, 32'h0, 32'h0000007F, 4'd0);
    add_req(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 4'd0);
    add_req(1'b0, F3_HU, 32'h22, 32'h0, 32'h0000BEEF, 4'd0);
    add_req(1'b0, F3_W,  32'h30, 32'h0, 32'h0123AA67, 4'd0);
    add_req(1'b0, F3_W,  32'h0,  32'h0, 32'h55AA55AA, 4'd0);
    run_stream("stall", 4, 6);

    // Reset with two loads in flight and the first one already presented.
    single("sw50", 1'b1, F3_W, 32'h50, 32'hCAFEF00D, 32'h0, 4'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h50;
    @(posedge clk);
    #1 req_addr = 32'h54;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check_eq("rstmid.pre", {31'd0, resp_valid3}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid.valid", {31'd0, resp_valid3}, 32'd0);
    check_eq("rstmid.rdata", resp_rdata3, 32'd0);
    check_eq("rstmid.ready", {31'd0, req_ready3}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid3) extra++;
    end
    check_eq("rstmid.noresp", extra, 32'd0);
    $display("txn rstmid reset with loads in flight -> late responses=%0d", extra);
    single("lw50", 1'b0, F3_W, 32'h50, 32'h0, 32'hCAFEF00D, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_pipe.md
DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, memory size in 32-bit words; power of two, 16..65536.
REQ-002 Parameter LATENCY, default 1, cycles from request acceptance to resp_valid; legal 1..4.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request can be accepted this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I load/store funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw).
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  consumer accepts response.
REQ-013 resp_rdata  output  32  load result, extended per funct3; 0 for stores and faults.
REQ-014 resp_exception  output  1  request faulted.
REQ-015 resp_exc_code  output  4  RISC-V mcause code of fault; 0 when no fault.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-017 req_ready SHALL equal !(resp_valid && !resp_ready); when low, the whole pipeline SHALL hold, with no stage advancing and no memory write.
REQ-018 Each accepted request SHALL produce exactly one response, in order, LATENCY cycles after acceptance when not stalled; stores also receive a response as acknowledgement.
REQ-019 Stores SHALL commit to memory on the acceptance edge; a load accepted on any later edge SHALL return the updated data (back-to-back store→load to the same word returns the new bytes).
REQ-020 Stores SHALL write only the addressed byte lanes: sb 1 lane by addr[1:0], sh 2 lanes by addr[1], sw 4 lanes.
REQ-021 Loads SHALL extract the addressed lane(s) and sign-extend (lb, lh) or zero-extend (lbu, lhu); lw returns the full word.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; an address with any set bit above that range SHALL be an access fault.
REQ-023 Misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0) SHALL fault with code 4 (load) or 6 (store).
REQ-024 Out-of-range address or illegal funct3 (load 011/110/111, store ≥011) SHALL fault with code 5 (load) or 7 (store); misalignment takes priority.
REQ-025 A faulting request SHALL NOT modify memory and SHALL respond with resp_rdata=0, resp_exception=1.
REQ-026 Response outputs SHALL be registered and stable while resp_valid && !resp_ready.
REQ-027 Accept and response handoff in the same cycle SHALL be supported, sustaining one request per cycle.

Reset
REQ-028 While rst_n=0: resp_valid=0, all pipeline valid bits 0, resp_rdata=0, resp_exception=0, resp_exc_code=0, req_ready=1.
REQ-029 Reset mid-operation SHALL discard in-flight responses; stores already committed SHALL remain; memory array contents are not reset.
REQ-030 The first request after rst_n deasserts SHALL be accepted on the first rising edge.

Structure
REQ-031 Package dmem_pkg SHALL hold funct3 encodings, exception-code constants and the pipeline-stage record type.
REQ-032 Sub-module dmem_lane_fmt (combinational) SHALL produce store byte-enables/aligned write data and load extract/extension; instantiated once.
REQ-033 Memory SHALL be a byte-enable-writable array inferable as block RAM; extra latency stages are registers after the array read.

Verification
REQ-034 sw 0xDEADBEEF @0x10, then lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDEAD.
REQ-035 sw 0x00000000 @0x20, sb 0x7F @0x21, lw @0x20 next cycle → 0x00007F00, no fault.
REQ-036 lw @0x22 → exception=1, code 4; sh @0x31 → code 6, memory word @0x30 unchanged.
REQ-037 DEPTH_WORDS=1024: lw @0x1000 → code 5; sw @0x1000 → code 7; funct3=011 load → code 5.
REQ-038 LATENCY=3, 8 back-to-back loads, resp_ready held low cycles 4–6 → req_ready low in those cycles, 8 in-order responses, none lost or duplicated.
REQ-039 Reset asserted with 2 loads in flight → resp_valid 0 immediately, no response after release; prior store data still readable.
